lod_share_arbiter: RTL

Round-robin arbiter that time-shares one `leading_one_detector` instance among `NUM_REQ` requesters in the floating-point accumulator's normalization stage. Each cycle it grants at most one valid request, normalizes the granted value (left-shifts the leading one to the MSB) and registers the result with the winning requester's ID. The output is a single-entry register under a valid/ready handshake. Throughput is one result per cycle when the consumer does not stall.

---
 rtl/lod_share_pkg.sv | 44 ++++
 rtl/leading_one_detector.sv | 24 ++
 rtl/lod_share_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lod_share_pkg.sv
// Shared types and helpers for the leading-one-detector share arbiter.
// The package holds the default configuration widths and the round-robin
// pick function used by the arbiter top.
package lod_share_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);
  localparam int SHIFT_W     = $clog2(WIDTH_DEF);

  // rr_pick works on a fixed maximum requester count so one function serves
  // every instance; callers zero-extend their valid vector and pointer.
  localparam int RR_MAX_REQ = 64;
  localparam int RR_IDX_W   = 6;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] winner;
  } rr_pick_t;

  // First valid requester in the order ptr, ptr+1, ... wrapping at num_req.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int                    num_req);
    rr_pick_t          r;
    logic [RR_IDX_W:0] idx;
    r.found  = 1'b0;
    r.winner = '0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req) begin
        idx = {1'b0, ptr} + (RR_IDX_W + 1)'(k);
        if (idx >= (RR_IDX_W + 1)'(num_req)) begin
          idx = idx - (RR_IDX_W + 1)'(num_req);
        end
        if (!r.found && valid[idx[RR_IDX_W-1:0]]) begin
          r.found  = 1'b1;
          r.winner = idx[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Reports the bit position of the most significant set bit of value.
// position is meaningless when found is low.
module leading_one_detector #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH)-1:0] position,
  output logic                     found
);

  localparam int PW = $clog2(WIDTH);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    position = '0;
    found    = |value;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        position = PW'(i);
      end
    end
  end

endmodule

// File: rtl/lod_share_arbiter.sv
// Round-robin arbiter sharing one leading_one_detector among NUM_REQ
// requesters. The granted value is normalized (leading one moved to the MSB)
// and captured in a single-entry valid/ready output register together with
// the winner's ID. NUM_REQ is limited to the rr_pick maximum of 64.
module lod_share_arbiter
  import lod_share_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_value,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic [WIDTH-1:0]           out_value,
  output logic [$clog2(WIDTH)-1:0]   out_shift,
  output logic                       out_zero
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SHW = $clog2(WIDTH);

  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   ptr_next;
  logic             out_valid_reg;
  logic [IDW-1:0]   out_id_reg;
  logic [WIDTH-1:0] out_value_reg;
  logic [SHW-1:0]   out_shift_reg;
  logic             out_zero_reg;

  rr_pick_t         pick;
  logic [IDW-1:0]   winner_id;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] sel_value;
  logic [SHW-1:0]   lod_pos;
  logic             lod_found;
  logic [SHW-1:0]   shift_next;
  logic [WIDTH-1:0] value_next;
  logic             zero_next;

  assign pick      = rr_pick(RR_MAX_REQ'(req_valid), RR_IDX_W'(ptr_reg), NUM_REQ);
  assign winner_id = IDW'(pick.winner);
  assign accept    = !out_valid_reg || out_ready;
  // rst_n gating keeps req_ready low for the whole reset, not just its edge.
  assign load      = rst_n && accept && pick.found;

  // Grant strobes depend only on valids, pointer and output handshake state.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = load && (pick.winner == RR_IDX_W'(gi));
    end
  endgenerate

  // Route the winning requester's value to the shared detector.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.winner == RR_IDX_W'(i)) begin
        sel_value = req_value[i*WIDTH +: WIDTH];
      end
    end
  end

  leading_one_detector #(
    .WIDTH(WIDTH)
  ) u_lod (
    .value   (sel_value),
    .position(lod_pos),
    .found   (lod_found)
  );

  // Barrel shift; an all-zero value reports zero with no shift, ignoring lod_pos.
  always_comb begin
    shift_next = '0;
    value_next = '0;
    zero_next  = 1'b1;
    if (lod_found) begin
      shift_next = SHW'(WIDTH - 1) - lod_pos;
      value_next = sel_value << shift_next;
      zero_next  = 1'b0;
    end
  end

  // Pointer moves one past the winner, wrapping explicitly for any NUM_REQ.
  always_comb begin
    ptr_next = winner_id + IDW'(1);
    if (winner_id == IDW'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end
  end

  // Output register and pointer: load on grant, clear valid on a bare drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_id_reg    <= '0;
      out_value_reg <= '0;
      out_shift_reg <= '0;
      out_zero_reg  <= 1'b0;
      ptr_reg       <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_id_reg    <= winner_id;
      out_value_reg <= value_next;
      out_shift_reg <= shift_next;
      out_zero_reg  <= zero_next;
      ptr_reg       <= ptr_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_id    = out_id_reg;
  assign out_value = out_value_reg;
  assign out_shift = out_shift_reg;
  assign out_zero  = out_zero_reg;

endmodule
